// File: rtl/iqmod_nco.sv
// rtl/iqmod_nco.sv - NCO-driven IQ upconverter producing offset-binary DAC codes.
// All state moves on the falling clock edge so the DAC can latch on the rising edge.
module iqmod_nco #(
  parameter int             IQW       = 8,
  parameter int             AMPW      = 8,
  parameter int             DACW      = 10,
  parameter int             PHW       = 16,
  parameter int             LUTAW     = 5,
  parameter logic [PHW-1:0] PINC_DEF  = 16'h1000,
  parameter int             OSHIFT    = IQW + AMPW - DACW,
  parameter bit             SYNC_WRAP = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [PHW-1:0]         pinc,
  input  logic                   pinc_ld,
  input  logic                   phase_clr,
  input  logic signed [IQW-1:0]  i,
  input  logic signed [IQW-1:0]  q,
  input  logic                   iq_valid,
  output logic                   iq_ready,
  output logic [DACW-1:0]        dacval,
  output logic                   dac_valid,
  output logic                   sat,
  input  logic                   sat_clr
);

  localparam int N    = 1 << LUTAW;
  localparam int PW   = IQW + AMPW;
  localparam int SW   = PW + 1;
  localparam int DW   = ((SW > DACW) ? SW : DACW) + 2;
  localparam int AMAX = (1 << (AMPW - 1)) - 1;

  localparam logic signed [DW-1:0] D_MID = DW'(2 ** (DACW - 1));
  localparam logic signed [DW-1:0] D_TOP = DW'(2 ** DACW - 1);
  localparam logic [DACW-1:0]      MID   = DACW'(2 ** (DACW - 1));

  // Rounded half away from zero so the table is symmetric about the axes.
  function automatic logic signed [AMPW-1:0] f_lut(input int k, input bit is_sin);
    real ang;
    real v;
    int  r;
    ang = 2.0 * 3.141592653589793 * real'(k) / real'(N);
    v   = (is_sin ? $sin(ang) : $cos(ang)) * real'(AMAX);
    r   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return AMPW'(r);
  endfunction

  logic signed [AMPW-1:0] w_cos_tab [N];
  logic signed [AMPW-1:0] w_sin_tab [N];

  for (genvar g = 0; g < N; g++) begin : g_lut
    localparam logic signed [AMPW-1:0] C_VAL = f_lut(g, 1'b0);
    localparam logic signed [AMPW-1:0] S_VAL = f_lut(g, 1'b1);
    assign w_cos_tab[g] = C_VAL;
    assign w_sin_tab[g] = S_VAL;
  end

  logic [PHW-1:0]         r_acc;
  logic [PHW-1:0]         r_step;
  logic [PHW-1:0]         w_acc_sum;
  logic [LUTAW-1:0]       w_k;
  logic signed [IQW-1:0]  r_act_i;
  logic signed [IQW-1:0]  r_act_q;

  assign w_acc_sum = r_acc + r_step;
  assign w_k       = r_acc[PHW-1 -: LUTAW];

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_step <= PINC_DEF;
    end else begin
      if (phase_clr) begin
        r_acc <= '0;
      end else if (en) begin
        r_acc <= w_acc_sum;
      end
      if (pinc_ld) begin
        r_step <= pinc;
      end
    end
  end

  if (SYNC_WRAP) begin : g_sync
    logic                  r_pend_full;
    logic signed [IQW-1:0] r_pend_i;
    logic signed [IQW-1:0] r_pend_q;
    logic                  w_wrap;
    logic                  w_xfer;

    // The sum is smaller than the old phase exactly when the add carried out.
    assign w_wrap   = en & ~phase_clr & (w_acc_sum < r_acc);
    assign iq_ready = ~r_pend_full;
    assign w_xfer   = iq_valid & ~r_pend_full;

    always_ff @(negedge clk) begin
      if (!rst_n) begin
        r_pend_full <= 1'b0;
        r_pend_i    <= '0;
        r_pend_q    <= '0;
        r_act_i     <= '0;
        r_act_q     <= '0;
      end else begin
        if (w_xfer) begin
          r_pend_i    <= i;
          r_pend_q    <= q;
          r_pend_full <= 1'b1;
        end else if (w_wrap) begin
          r_pend_full <= 1'b0;
        end
        if (w_wrap && r_pend_full) begin
          r_act_i <= r_pend_i;
          r_act_q <= r_pend_q;
        end
      end
    end
  end else begin : g_direct
    assign iq_ready = 1'b1;

    always_ff @(negedge clk) begin
      if (!rst_n) begin
        r_act_i <= '0;
        r_act_q <= '0;
      end else if (iq_valid) begin
        r_act_i <= i;
        r_act_q <= q;
      end
    end
  end

  logic signed [AMPW-1:0] r_c1;
  logic signed [AMPW-1:0] r_s1;
  logic signed [IQW-1:0]  r_i1;
  logic signed [IQW-1:0]  r_q1;
  logic                   r_v1;
  logic signed [PW-1:0]   r_pi;
  logic signed [PW-1:0]   r_pq;
  logic                   r_v2;
  logic [DACW-1:0]        r_dac;
  logic                   r_v3;
  logic                   r_sat;

  logic signed [PW-1:0]   w_i_ext;
  logic signed [PW-1:0]   w_q_ext;
  logic signed [PW-1:0]   w_c_ext;
  logic signed [PW-1:0]   w_s_ext;
  logic signed [SW-1:0]   w_s;
  logic signed [SW-1:0]   w_sh;
  logic signed [DW-1:0]   w_shx;
  logic signed [DW-1:0]   w_d;
  logic                   w_lo;
  logic                   w_hi;
  logic [DACW-1:0]        w_dac_sat;

  assign w_i_ext = {{AMPW{r_i1[IQW-1]}}, r_i1};
  assign w_q_ext = {{AMPW{r_q1[IQW-1]}}, r_q1};
  assign w_c_ext = {{IQW{r_c1[AMPW-1]}}, r_c1};
  assign w_s_ext = {{IQW{r_s1[AMPW-1]}}, r_s1};

  assign w_s       = {r_pi[PW-1], r_pi} - {r_pq[PW-1], r_pq};
  assign w_sh      = w_s >>> OSHIFT;
  assign w_shx     = {{(DW - SW){w_sh[SW-1]}}, w_sh};
  assign w_d       = w_shx + D_MID;
  assign w_lo      = (w_d < 0);
  assign w_hi      = (w_d > D_TOP);
  assign w_dac_sat = w_lo ? '0 : (w_hi ? '1 : w_d[DACW-1:0]);

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      r_c1  <= '0;
      r_s1  <= '0;
      r_i1  <= '0;
      r_q1  <= '0;
      r_v1  <= 1'b0;
      r_pi  <= '0;
      r_pq  <= '0;
      r_v2  <= 1'b0;
      r_dac <= MID;
      r_v3  <= 1'b0;
      r_sat <= 1'b0;
    end else begin
      r_c1  <= w_cos_tab[w_k];
      r_s1  <= w_sin_tab[w_k];
      r_i1  <= r_act_i;
      r_q1  <= r_act_q;
      r_v1  <= en;
      r_pi  <= w_i_ext * w_c_ext;
      r_pq  <= w_q_ext * w_s_ext;
      r_v2  <= r_v1 & en;
      r_dac <= en ? w_dac_sat : MID;
      r_v3  <= r_v2 & en;
      // A saturation on the same edge as sat_clr must leave the flag set.
      if (en && r_v2 && (w_lo || w_hi)) begin
        r_sat <= 1'b1;
      end else if (sat_clr) begin
        r_sat <= 1'b0;
      end
    end
  end

  assign dacval    = r_dac;
  assign dac_valid = r_v3;
  assign sat       = r_sat;

endmodule

// File: tb/tb_iqmod_nco.sv
// tb/tb_iqmod_nco.sv - directed-vector bench for iqmod_nco (default, SYNC_WRAP=1, OSHIFT=5 builds).
module tb_iqmod_nco;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [15:0]       pinc;
  logic              pinc_ld;
  logic              phase_clr;
  logic signed [7:0] i;
  logic signed [7:0] q;
  logic              iq_valid;
  logic              sat_clr;

  logic       d_ready, d_vld, d_sat;
  logic [9:0] d_dac;
  logic       s_ready, s_vld, s_sat;
  logic [9:0] s_dac;
  logic       o_ready, o_vld, o_sat;
  logic [9:0] o_dac;

  int n_cmp = 0;
  int n_bad = 0;

  iqmod_nco u_d (
    .clk(clk), .rst_n(rst_n), .en(en), .pinc(pinc), .pinc_ld(pinc_ld),
    .phase_clr(phase_clr), .i(i), .q(q), .iq_valid(iq_valid), .iq_ready(d_ready),
    .dacval(d_dac), .dac_valid(d_vld), .sat(d_sat), .sat_clr(sat_clr)
  );

  iqmod_nco #(.SYNC_WRAP(1'b1)) u_s (
    .clk(clk), .rst_n(rst_n), .en(en), .pinc(pinc), .pinc_ld(pinc_ld),
    .phase_clr(phase_clr), .i(i), .q(q), .iq_valid(iq_valid), .iq_ready(s_ready),
    .dacval(s_dac), .dac_valid(s_vld), .sat(s_sat), .sat_clr(sat_clr)
  );

  iqmod_nco #(.OSHIFT(5)) u_o (
    .clk(clk), .rst_n(rst_n), .en(en), .pinc(pinc), .pinc_ld(pinc_ld),
    .phase_clr(phase_clr), .i(i), .q(q), .iq_valid(iq_valid), .iq_ready(o_ready),
    .dacval(o_dac), .dac_valid(o_vld), .sat(o_sat), .sat_clr(sat_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One falling (active) edge; returns at the following rising edge for sampling.
  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
  endtask

  typedef struct {
    logic              en;
    logic signed [7:0] i;
    logic signed [7:0] q;
    logic [9:0]        dac;
    logic              vld;
  } vec_t;

  vec_t tbl [19];
  int   e_dac [19] = '{512, 512, 764, 744, 690, 609, 512, 414, 333, 279,
                       259, 279, 333, 414, 512, 609, 690, 744, 764};

  initial begin
    for (int n = 0; n < 19; n++) begin
      tbl[n] = '{1'b1, 8'sd127, 8'sd0, 10'(e_dac[n]), (n >= 2)};
    end

    rst_n = 1'b0; en = 1'b0; pinc = '0; pinc_ld = 1'b0; phase_clr = 1'b0;
    i = '0; q = '0; iq_valid = 1'b0; sat_clr = 1'b0;
    cyc(); cyc();
    chk("rst dacval", d_dac, 512);
    chk("rst dac_valid", d_vld, 0);
    chk("rst iq_ready", d_ready, 1);
    chk("rst sync iq_ready", s_ready, 1);
    chk("rst sat", d_sat, 0);
    chk("rst acc", u_d.r_acc, 0);
    chk("rst step", u_d.r_step, 16'h1000);

    // Cosine sweep with i=127: k steps by 2 per clock, period 16.
    rst_n = 1'b1; i = 8'sd127; q = 8'sd0; iq_valid = 1'b1;
    cyc();
    for (int n = 0; n < 19; n++) begin
      en = tbl[n].en; i = tbl[n].i; q = tbl[n].q;
      cyc();
      chk($sformatf("tbl[%0d] dacval", n), d_dac, tbl[n].dac);
      chk($sformatf("tbl[%0d] dac_valid", n), d_vld, tbl[n].vld);
    end

    // Sine path with q=127, fresh phase.
    en = 1'b0; i = 8'sd0; q = 8'sd127; iq_valid = 1'b1; phase_clr = 1'b1;
    cyc();
    chk("clr acc", u_d.r_acc, 0);
    phase_clr = 1'b0; iq_valid = 1'b0; en = 1'b1;
    for (int f = 1; f <= 15; f++) begin
      cyc();
      if (f == 3)  chk("q k0", d_dac, 512);
      if (f == 7)  chk("q k8", d_dac, 259);
      if (f == 11) chk("q k16", d_dac, 512);
      if (f == 15) chk("q k24", d_dac, 764);
    end

    // New step and phase clear on the same edge; one LUT point per clock.
    pinc = 16'h0800; pinc_ld = 1'b1; phase_clr = 1'b1;
    cyc();
    chk("ld+clr acc", u_d.r_acc, 0);
    chk("ld+clr step", u_d.r_step, 16'h0800);
    pinc_ld = 1'b0; phase_clr = 1'b0;
    for (int g = 1; g <= 32; g++) begin
      cyc();
      if (g == 1)  chk("slow acc g1", u_d.r_acc, 16'h0800);
      if (g == 11) chk("slow k8", d_dac, 259);
      if (g == 11) chk("slow k8 valid", d_vld, 1);
      if (g == 19) chk("slow k16", d_dac, 512);
      if (g == 27) chk("slow k24", d_dac, 764);
      if (g == 32) chk("slow acc period", u_d.r_acc, 0);
    end

    en = 1'b0;
    cyc();
    chk("en0 dacval", d_dac, 512);
    chk("en0 dac_valid", d_vld, 0);
    chk("en0 acc frozen", u_d.r_acc, 0);
    cyc();
    chk("en0 acc frozen 2", u_d.r_acc, 0);
    en = 1'b1;
    cyc();
    chk("reen e1 valid", d_vld, 0);
    chk("reen e1 acc", u_d.r_acc, 16'h0800);
    cyc();
    chk("reen e2 valid", d_vld, 0);
    cyc();
    chk("reen e3 valid", d_vld, 1);

    // Wrap-synchronised handshake.
    rst_n = 1'b0; en = 1'b0; iq_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("sw ready idle", s_ready, 1);
    i = 8'sd100; q = 8'sd0; iq_valid = 1'b1;
    cyc();
    chk("sw A taken ready", s_ready, 0);
    chk("sw A not active", u_s.r_act_i, 0);
    i = 8'sd50;
    cyc(); cyc();
    chk("sw B waits", s_ready, 0);
    en = 1'b1;
    for (int w = 1; w <= 17; w++) begin
      cyc();
      if (w == 15) chk("sw pre-wrap ready", s_ready, 0);
      if (w == 15) chk("sw pre-wrap active", u_s.r_act_i, 0);
      if (w == 16) chk("sw wrap ready", s_ready, 1);
      if (w == 16) chk("sw wrap active", u_s.r_act_i, 100);
      if (w == 17) chk("sw B taken ready", s_ready, 0);
      if (w == 17) chk("sw B not active", u_s.r_act_i, 100);
    end
    en = 1'b0;
    for (int h = 0; h < 20; h++) begin
      pinc_ld = (h == 5); pinc = 16'h0400;
      cyc();
    end
    chk("sw hold ready", s_ready, 0);
    chk("sw hold active", u_s.r_act_i, 100);
    chk("sw step loaded", u_s.r_step, 16'h0400);

    rst_n = 1'b0;
    cyc();
    chk("sw rst ready", s_ready, 1);
    chk("sw rst active", u_s.r_act_i, 0);
    chk("sw rst step", u_s.r_step, 16'h1000);
    chk("sw rst acc", u_s.r_acc, 0);

    // Saturation with OSHIFT=5.
    rst_n = 1'b1; en = 1'b0; i = 8'sd127; q = -8'sd128; iq_valid = 1'b1;
    cyc();
    en = 1'b1;
    cyc(); cyc();
    chk("os e2 dacval", o_dac, 512);
    cyc();
    chk("os k0 dacval", o_dac, 1016);
    chk("os k0 sat", o_sat, 0);
    sat_clr = 1'b1;
    cyc();
    chk("os k2 dacval", o_dac, 1023);
    chk("os set beats clr", o_sat, 1);
    sat_clr = 1'b0;
    cyc();
    chk("os k4 dacval", o_dac, 1023);
    chk("os k4 sat", o_sat, 1);
    en = 1'b0; sat_clr = 1'b1;
    cyc();
    chk("os sat cleared", o_sat, 0);
    chk("os en0 dacval", o_dac, 512);
    sat_clr = 1'b0; i = -8'sd128; q = 8'sd0; phase_clr = 1'b1;
    cyc();
    phase_clr = 1'b0; iq_valid = 1'b0; en = 1'b1;
    cyc(); cyc(); cyc();
    chk("os neg k0 dacval", o_dac, 4);
    chk("os neg sat", o_sat, 0);
    chk("os neg valid", o_vld, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
